// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register address/data widths, typed aliases and
// the special register numbers used by the register file.
package cpu_pkg;

  localparam int REG_AW = 5;
  localparam int DW     = 32;
  localparam int NREG   = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DW-1:0]     word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;

  // R0 is hard-wired to zero; every path that touches it asks this.
  function automatic logic is_zero_reg(input reg_addr_t a);
    return (a == REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Register file bus: read addresses/data, GPR writeback with overflow
// qualification, HI/LO write and readback, and the trap flag.
interface reg_file_if;
  import cpu_pkg::*;

  reg_addr_t  ra_addr;
  reg_addr_t  rb_addr;
  word_t      bus_a;
  word_t      bus_b;
  logic       wr_en;
  reg_addr_t  wr_addr;
  word_t      wr_data;
  logic       ovf_chk;
  logic       alu_ovf;
  logic [1:0] hilo_we;
  word_t      hi_in;
  word_t      lo_in;
  word_t      hi_out;
  word_t      lo_out;
  logic       ovf_trap;

  // Datapath side: drives addresses and writeback, consumes read data.
  modport master (
    output ra_addr, rb_addr, wr_en, wr_addr, wr_data, ovf_chk, alu_ovf,
           hilo_we, hi_in, lo_in,
    input  bus_a, bus_b, hi_out, lo_out, ovf_trap
  );

  // Register file side.
  modport slave (
    input  ra_addr, rb_addr, wr_en, wr_addr, wr_data, ovf_chk, alu_ovf,
           hilo_we, hi_in, lo_in,
    output bus_a, bus_b, hi_out, lo_out, ovf_trap
  );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port of the register file: address decode,
// R0 zero-force and, when RF_BYPASS_EN is defined, same-cycle
// write-through of the qualified write data.
module rf_read_port
  import cpu_pkg::*;
(
  output word_t     o_data,
  input  reg_addr_t i_addr,
  input  word_t     i_regs [NREG]
`ifdef RF_BYPASS_EN
  ,
  input  logic      i_we,
  input  reg_addr_t i_wr_addr,
  input  word_t     i_wr_data
`endif
);

  // Select stored word, optionally forward the in-flight write, force R0 to 0.
  always_comb begin
    o_data = i_regs[i_addr];
`ifdef RF_BYPASS_EN
    if (i_we && (i_wr_addr == i_addr)) begin
      o_data = i_wr_data;
    end
`endif
    if (is_zero_reg(i_addr)) begin
      o_data = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit GPR file plus HI/LO for the single-cycle datapath.
// A trapping add/sub that overflows suppresses its GPR write and raises
// ovf_trap for one cycle. Optional feature macro: RF_BYPASS_EN (read ports
// return the qualified write data in the same cycle).
module reg_file
  import cpu_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  reg_file_if.slave  rf
);

  logic  w_trap_cond;
  logic  w_we_eff;
  word_t w_regs [NREG];
  word_t w_bus_a;
  word_t w_bus_b;
  word_t r_gpr [1:NREG-1];
  word_t r_hi;
  word_t r_lo;
  logic  r_ovf_trap;

  assign w_trap_cond = rf.ovf_chk & rf.alu_ovf;
  assign w_we_eff    = rf.wr_en & ~is_zero_reg(rf.wr_addr) & ~w_trap_cond;

  // R0 has no storage; the read view sees a constant zero there.
  assign w_regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_gpr
      // One GPR: loads wr_data when the qualified write targets it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_gpr[gi] <= '0;
        end else if (w_we_eff && (rf.wr_addr == reg_addr_t'(gi))) begin
          r_gpr[gi] <= rf.wr_data;
        end
      end
      assign w_regs[gi] = r_gpr[gi];
    end
  endgenerate

  // HI and LO load independently and ignore the overflow qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (rf.hilo_we[1]) r_hi <= rf.hi_in;
      if (rf.hilo_we[0]) r_lo <= rf.lo_in;
    end
  end

  // Trap flag: any suppressed write request, including one aimed at R0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_trap <= 1'b0;
    end else begin
      r_ovf_trap <= rf.wr_en & w_trap_cond;
    end
  end

  rf_read_port u_port_a (
    .o_data    (w_bus_a),
    .i_addr    (rf.ra_addr),
    .i_regs    (w_regs)
`ifdef RF_BYPASS_EN
    ,
    .i_we      (w_we_eff),
    .i_wr_addr (rf.wr_addr),
    .i_wr_data (rf.wr_data)
`endif
  );

  rf_read_port u_port_b (
    .o_data    (w_bus_b),
    .i_addr    (rf.rb_addr),
    .i_regs    (w_regs)
`ifdef RF_BYPASS_EN
    ,
    .i_we      (w_we_eff),
    .i_wr_addr (rf.wr_addr),
    .i_wr_data (rf.wr_data)
`endif
  );

  assign rf.bus_a    = w_bus_a;
  assign rf.bus_b    = w_bus_b;
  assign rf.hi_out   = r_hi;
  assign rf.lo_out   = r_lo;
  assign rf.ovf_trap = r_ovf_trap;

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file: reset state, GPR writes, R0, overflow
// suppression and trap flag, same-cycle read/write (both builds), HI/LO,
// and asynchronous reset overriding a pending write.
module tb_reg_file;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  reg_file_if rf_bus ();

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it; mismatches carry FAIL.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, act);
    end
  endtask

  task automatic idle_inputs();
    rf_bus.wr_en   = 1'b0;
    rf_bus.wr_addr = '0;
    rf_bus.wr_data = '0;
    rf_bus.ovf_chk = 1'b0;
    rf_bus.alu_ovf = 1'b0;
    rf_bus.hilo_we = 2'b00;
    rf_bus.hi_in   = '0;
    rf_bus.lo_in   = '0;
  endtask

  // Present one GPR write at the negedge, take it at the next posedge.
  task automatic gpr_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic chk, input logic ovf);
    @(negedge clk);
    rf_bus.wr_en   = 1'b1;
    rf_bus.wr_addr = addr;
    rf_bus.wr_data = data;
    rf_bus.ovf_chk = chk;
    rf_bus.alu_ovf = ovf;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic read_a(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    rf_bus.ra_addr = addr;
    #1;
    check(tag, rf_bus.bus_a, exp);
  endtask

  logic [31:0] exp_same;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    rf_bus.ra_addr = '0;
    rf_bus.rb_addr = '0;
    idle_inputs();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      rf_bus.ra_addr = 5'(i);
      #0.1;
      check($sformatf("reset_ra%0d", i), rf_bus.bus_a, 32'h0);
    end
    check("reset_hi", rf_bus.hi_out, 32'h0);
    check("reset_lo", rf_bus.lo_out, 32'h0);
    check("reset_trap", {31'b0, rf_bus.ovf_trap}, 32'h0);
    rst_n = 1'b1;

    // Basic write/read on both ports
    gpr_write(5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    rf_bus.ra_addr = 5'd5;
    rf_bus.rb_addr = 5'd5;
    #1;
    check("r5_bus_a", rf_bus.bus_a, 32'hDEADBEEF);
    check("r5_bus_b", rf_bus.bus_b, 32'hDEADBEEF);

    // R0 discards writes
    gpr_write(5'd0, 32'h00001234, 1'b0, 1'b0);
    read_a(5'd0, 32'h0, "r0_after_write");
    check("r0_no_trap", {31'b0, rf_bus.ovf_trap}, 32'h0);

    // Overflow suppresses write and raises trap for one cycle
    gpr_write(5'd7, 32'h00000011, 1'b0, 1'b0);
    gpr_write(5'd7, 32'h80000000, 1'b1, 1'b1);
    read_a(5'd7, 32'h00000011, "r7_ovf_blocked");
    check("trap_set", {31'b0, rf_bus.ovf_trap}, 32'h1);
    @(posedge clk); #1;
    check("trap_one_cycle", {31'b0, rf_bus.ovf_trap}, 32'h0);
    gpr_write(5'd7, 32'h80000000, 1'b0, 1'b1);
    read_a(5'd7, 32'h80000000, "r7_no_chk");
    check("trap_no_chk", {31'b0, rf_bus.ovf_trap}, 32'h0);

    // Trap flag still reported when the destination is R0
    gpr_write(5'd0, 32'h00000001, 1'b1, 1'b1);
    check("trap_r0_dest", {31'b0, rf_bus.ovf_trap}, 32'h1);

    // Same-cycle write and read of R9
    gpr_write(5'd9, 32'h00001111, 1'b0, 1'b0);
    @(negedge clk);
    rf_bus.wr_en   = 1'b1;
    rf_bus.wr_addr = 5'd9;
    rf_bus.wr_data = 32'hA5A5A5A5;
    rf_bus.ra_addr = 5'd9;
    rf_bus.rb_addr = 5'd5;
    #1;
`ifdef RF_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'h00001111;
`endif
    check("same_cycle_r9", rf_bus.bus_a, exp_same);
    check("same_cycle_other", rf_bus.bus_b, 32'hDEADBEEF);
    @(posedge clk); #1;
    idle_inputs();
    read_a(5'd9, 32'hA5A5A5A5, "r9_after_edge");

    // Suppressed write never forwards
    @(negedge clk);
    rf_bus.wr_en   = 1'b1;
    rf_bus.wr_addr = 5'd9;
    rf_bus.wr_data = 32'h0BAD0BAD;
    rf_bus.ovf_chk = 1'b1;
    rf_bus.alu_ovf = 1'b1;
    rf_bus.rb_addr = 5'd9;
    #1;
    check("no_bypass_on_ovf", rf_bus.bus_b, 32'hA5A5A5A5);
    @(posedge clk); #1;
    idle_inputs();

    // Same-cycle write to R0 reads 0
    @(negedge clk);
    rf_bus.wr_en   = 1'b1;
    rf_bus.wr_addr = 5'd0;
    rf_bus.wr_data = 32'hFFFFFFFF;
    rf_bus.ra_addr = 5'd0;
    #1;
    check("same_cycle_r0", rf_bus.bus_a, 32'h0);
    @(posedge clk); #1;
    idle_inputs();

    // HI/LO independent writes, not gated by overflow
    @(negedge clk);
    rf_bus.hilo_we = 2'b10;
    rf_bus.hi_in   = 32'hFFFF0000;
    rf_bus.lo_in   = 32'h12345678;
    @(posedge clk); #1;
    idle_inputs();
    check("hi_only_hi", rf_bus.hi_out, 32'hFFFF0000);
    check("hi_only_lo", rf_bus.lo_out, 32'h0);
    @(negedge clk);
    rf_bus.hilo_we = 2'b01;
    rf_bus.hi_in   = 32'h01010101;
    rf_bus.lo_in   = 32'h12345678;
    @(posedge clk); #1;
    idle_inputs();
    check("lo_only_hi", rf_bus.hi_out, 32'hFFFF0000);
    check("lo_only_lo", rf_bus.lo_out, 32'h12345678);
    @(negedge clk);
    rf_bus.hilo_we = 2'b11;
    rf_bus.ovf_chk = 1'b1;
    rf_bus.alu_ovf = 1'b1;
    rf_bus.hi_in   = 32'hAAAA5555;
    rf_bus.lo_in   = 32'h5555AAAA;
    @(posedge clk); #1;
    idle_inputs();
    check("both_ovf_hi", rf_bus.hi_out, 32'hAAAA5555);
    check("both_ovf_lo", rf_bus.lo_out, 32'h5555AAAA);

    // Asynchronous reset overrides a pending write to R31
    gpr_write(5'd31, 32'h00000400, 1'b0, 1'b0);
    read_a(5'd31, 32'h00000400, "r31_written");
    @(negedge clk);
    rf_bus.wr_en   = 1'b1;
    rf_bus.wr_addr = 5'd31;
    rf_bus.wr_data = 32'h00000800;
    #2;
    rst_n = 1'b0;
    #1;
    check("r31_async_reset", rf_bus.bus_a, 32'h0);
    check("hi_async_reset", rf_bus.hi_out, 32'h0);
    check("lo_async_reset", rf_bus.lo_out, 32'h0);
    @(posedge clk); #1;
    check("r31_in_reset_edge", rf_bus.bus_a, 32'h0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("r31_after_release", rf_bus.bus_a, 32'h0);
    rf_bus.rb_addr = 5'd5;
    #1;
    check("r5_after_reset", rf_bus.bus_b, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
